dco_nco: RTL and testbench
==========================

// Module: dco_nco
// PURPOSE
//  Digitally controlled oscillator: the consumer of the 16-bit loop-filter control word in the PLL.
//  Maps the signed control word to a frequency tuning word (FTW) around a centre frequency.
//  Integrates the FTW in a phase accumulator; the accumulator MSB is the PLL output clock fed back to the PFD.
//  New FTW values are applied only at phase wrap, so each output period is generated by exactly one FTW.
// PARAMETERS
//  ACC_W     24          phase accumulator width (bits)
//  CTRL_W    16          control word width; two's complement
//  CENTER    24'h010000  FTW applied for ctrl = 0 (free-running frequency)
//  KV_SHIFT  4           DCO gain: FTW offset = sext(ctrl) << KV_SHIFT
//  FTW_MIN   24'h000100  lower FTW clamp (must be > 0)
//  FTW_MAX   24'h080000  upper FTW clamp (must be <= 2^(ACC_W-1) for a valid MSB clock)
// PORTS
//  clk       in   1       single clock domain
//  rst       in   1       synchronous, active-high reset
//  en        in   1       1 = accumulator runs; 0 = phase frozen
//  ctrl      in   CTRL_W  loop-filter control word, two's complement, sampled every cycle
//  dco_out   out  1       oscillator output = phase[ACC_W-1]
//  dco_tick  out  1       one-cycle pulse in the cycle after a phase wrap
//  phase     out  ACC_W   accumulator value (registered)
//  ftw       out  ACC_W   FTW currently driving the accumulator (ftw_active)
//  sat_hi    out  1       pending FTW clamped to FTW_MAX
//  sat_lo    out  1       pending FTW clamped to FTW_MIN
// BEHAVIOUR
//  Reset (rst=1 at posedge; overrides en): ctrl_q=0, ftw_pend=ftw_active=CENTER, phase=0.
//   Reset also sets dco_out=0, dco_tick=0, sat_hi=sat_lo=0. Mid-operation reset takes effect at that same edge.
//  Pipeline, stage 1: ctrl_q <= ctrl every cycle.
//  Pipeline, stage 2: sum = CENTER + (sext(ctrl_q) <<< KV_SHIFT), computed signed in ACC_W+2 bits (no overflow).
//   sum < FTW_MIN -> ftw_pend=FTW_MIN, sat_lo=1.
//   sum > FTW_MAX -> ftw_pend=FTW_MAX, sat_hi=1.
//   Otherwise ftw_pend=sum[ACC_W-1:0] and both flags are 0. Flags are registered with ftw_pend.
//  Accumulator (en=1): {carry, phase} <= phase + ftw_active. carry=1 is a wrap.
//  On the wrap edge: ftw_active <= ftw_pend, using the value registered before that edge.
//  dco_tick=1 during the cycle that follows the wrap edge, otherwise 0.
//  en=0: phase holds, no wrap, dco_tick=0. ftw_active <= ftw_pend every cycle (no glitch while stopped).
//  Latency: ctrl change -> ftw_pend after 2 edges -> ftw after the first wrap that follows.
//  Output period = 2^ACC_W / ftw_active cycles; dco_out high for the second half of each phase cycle.
//  Wrap and stage-2 update on the same edge: ftw_active takes the old ftw_pend; the new one waits for the next wrap.
//  ftw only changes on a wrap edge, while en=0, or at reset; no partial-period FTW mix.
// TESTING (ACC_W=24, default parameters)
//  T1 rst, then en=1, ctrl=0:
//     ftw=0x010000; dco_tick every 256 cycles; dco_out 128 cycles high, 128 low.
//  T2 ctrl=16'h1000 mid-period:
//     ftw_pend=0x020000 after 2 edges; ftw stays 0x010000 until the next tick; then period=128 cycles.
//  T3 ctrl=16'h8000:
//     ftw_pend=0x000100, sat_lo=1; after the next wrap, period=65536 cycles.
//  T4 ctrl=16'h7FFF (sum 0x08FFF0):
//     ftw_pend=0x080000, sat_hi=1; period=32 cycles; dco_out 16 high, 16 low.
//  T5 en=0 for 50 cycles mid-period:
//     phase constant, no tick; after en=1, the next tick comes 50 cycles late.
//  T6 rst for 1 cycle mid-run (ctrl=16'h1000):
//     next cycle phase=0, ftw=0x010000, flags=0, tick=0; after rst, ftw=0x020000 applied at the first wrap.

Source files
------------

// File: rtl/dco_nco.sv
// dco_nco: digitally controlled oscillator that turns a signed control word into a clamped FTW
// and integrates it in a phase accumulator, switching FTW only at phase wrap.
module dco_nco #(
   parameter int                ACC_W    = 24,
   parameter int                CTRL_W   = 16,
   parameter logic [ACC_W-1:0]  CENTER   = 24'h010000,
   parameter int                KV_SHIFT = 4,
   parameter logic [ACC_W-1:0]  FTW_MIN  = 24'h000100,
   parameter logic [ACC_W-1:0]  FTW_MAX  = 24'h080000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [CTRL_W-1:0] ctrl,
   output logic              dco_out,
   output logic              dco_tick,
   output logic [ACC_W-1:0]  phase,
   output logic [ACC_W-1:0]  ftw,
   output logic              sat_hi,
   output logic              sat_lo
);
   localparam int SW = ACC_W + 2;
   logic [CTRL_W-1:0]    ctrl_q;
   logic [ACC_W-1:0]     ftw_pend;
   logic signed [SW-1:0] sum;
   logic                 lo, hi;
   logic [ACC_W:0]       nxt;
   // Two guard bits keep the signed offset sum free of overflow before clamping
   assign sum = $signed({2'b00, CENTER}) + ($signed({{(SW-CTRL_W){ctrl_q[CTRL_W-1]}}, ctrl_q}) <<< KV_SHIFT);
   assign lo  = sum < $signed({2'b00, FTW_MIN});
   assign hi  = sum > $signed({2'b00, FTW_MAX});
   assign nxt = {1'b0, phase} + {1'b0, ftw};
   assign dco_out = phase[ACC_W-1];
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q   <= '0;
         ftw_pend <= CENTER;
         ftw      <= CENTER;
         phase    <= '0;
         dco_tick <= 1'b0;
         sat_hi   <= 1'b0;
         sat_lo   <= 1'b0;
      end else begin
         ctrl_q   <= ctrl;
         ftw_pend <= lo ? FTW_MIN : hi ? FTW_MAX : sum[ACC_W-1:0];
         sat_lo   <= lo;
         sat_hi   <= hi;
         if (en) begin
            phase    <= nxt[ACC_W-1:0];
            dco_tick <= nxt[ACC_W];
            if (nxt[ACC_W]) ftw <= ftw_pend;
         end else begin
            dco_tick <= 1'b0;
            ftw      <= ftw_pend;
         end
      end
   end
endmodule

// File: tb/tb_dco_nco.sv
// tb_dco_nco: directed checks of reset, tuning, clamping, pause and mid-run reset of dco_nco.
module tb_dco_nco;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [15:0] ctrl = '0;
   logic        dco_out, dco_tick, sat_hi, sat_lo;
   logic [23:0] phase, ftw;
   int          checks = 0;
   int          errors = 0;
   int          n, hc, ticks;

   dco_nco dut (
      .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .dco_out(dco_out), .dco_tick(dco_tick),
      .phase(phase), .ftw(ftw), .sat_hi(sat_hi), .sat_lo(sat_lo)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Steps until dco_tick is seen (bounded); returns edges taken and dco_out high samples
   task automatic wait_tick(input int limit, output int cnt, output int high);
      cnt = 0;
      high = 0;
      do begin
         step();
         cnt++;
         high += int'(dco_out);
      end while (!dco_tick && cnt < limit);
   endtask

   initial begin
      step();
      step();
      check("rst_phase", phase, 0);
      check("rst_ftw", ftw, 24'h010000);
      check("rst_tick", dco_tick, 0);
      check("rst_out", dco_out, 0);
      check("rst_sat", {sat_hi, sat_lo}, 0);
      rst = 1'b0;
      en = 1'b1;
      step();
      check("t1_phase1", phase, 24'h010000);
      wait_tick(1000, n, hc);
      check("t1_first_tick", n, 255);
      wait_tick(1000, n, hc);
      check("t1_period", n, 256);
      check("t1_high", hc, 128);
      check("t1_wrap_phase", phase, 0);

      ctrl = 16'h1000;
      step();
      step();
      check("t2_ftw_hold", ftw, 24'h010000);
      check("t2_sat", {sat_hi, sat_lo}, 0);
      wait_tick(1000, n, hc);
      check("t2_to_tick", n, 254);
      check("t2_ftw", ftw, 24'h020000);
      wait_tick(1000, n, hc);
      check("t2_period", n, 128);
      check("t2_high", hc, 64);

      ctrl = 16'h7FFF;
      step();
      step();
      check("t4_sat", {sat_hi, sat_lo}, 2'b10);
      check("t4_ftw_hold", ftw, 24'h020000);
      wait_tick(1000, n, hc);
      check("t4_to_tick", n, 126);
      check("t4_ftw", ftw, 24'h080000);
      wait_tick(1000, n, hc);
      check("t4_period", n, 32);
      check("t4_high", hc, 16);

      repeat (5) step();
      check("t5_phase", phase, 24'h280000);
      en = 1'b0;
      ticks = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         ticks += int'(dco_tick);
      end
      check("t5_no_tick", ticks, 0);
      check("t5_frozen", phase, 24'h280000);
      check("t5_ftw", ftw, 24'h080000);
      en = 1'b1;
      wait_tick(1000, n, hc);
      check("t5_resume", n, 27);

      ctrl = 16'h1000;
      repeat (10) step();
      check("t6_pre_phase", phase, 24'h500000);
      check("t6_pre_ftw", ftw, 24'h080000);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6_phase", phase, 0);
      check("t6_ftw", ftw, 24'h010000);
      check("t6_sat", {sat_hi, sat_lo}, 0);
      check("t6_tick", dco_tick, 0);
      wait_tick(1000, n, hc);
      check("t6_first_wrap", n, 256);
      check("t6_ftw_new", ftw, 24'h020000);
      wait_tick(1000, n, hc);
      check("t6_period", n, 128);

      ctrl = 16'h8000;
      step();
      step();
      check("t3_sat", {sat_hi, sat_lo}, 2'b01);
      wait_tick(1000, n, hc);
      check("t3_to_tick", n, 126);
      check("t3_ftw", ftw, 24'h000100);
      wait_tick(70000, n, hc);
      check("t3_period", n, 65536);
      check("t3_high", hc, 32768);
      check("t3_wrap_phase", phase, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
